// File: rtl/simul_axi_pkg.sv
// Shared constants for the simulation AXI trackers: burst type encodings and error-flag bit positions.
package simul_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    localparam int unsigned ERR_W        = 5;
    localparam int unsigned ERR_LAST     = 0;
    localparam int unsigned ERR_OVERRUN  = 1;
    localparam int unsigned ERR_UNDERRUN = 2;
    localparam int unsigned ERR_WRAP_LEN = 3;
    localparam int unsigned ERR_ID       = 4;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats (len = beats - 1)
    function automatic logic wrap_len_ok(input logic [31:0] len);
        return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
    endfunction

endpackage

// File: rtl/simul_fifo.sv
// Simple synchronous FIFO; a pushed entry appears at the head (dout/valid) on the cycle after the push.
module simul_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign valid   = (count != '0);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/simul_axi_read_tracker.sv
// Tracks AXI read bursts: queues AR commands, regenerates per-beat word addresses and flags protocol errors.
// Define SIMUL_AXI_READ_ID_CHECK_EN to also compare RID against the burst's ARID.
module simul_axi_read_tracker
    import simul_axi_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned ID_W       = 6,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rcmd,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [LEN_W-1:0]  rlen,
    input  logic [1:0]        rburst,
    input  logic [ID_W-1:0]   arid,
    input  logic              data_stb,
    input  logic              last,
    input  logic [ID_W-1:0]   rid,
    output logic [ADDR_W-1:0] addr_out,
    output logic              burst,
    output logic              err_out,
    output logic [ERR_W-1:0]  err_flags
);

    localparam int unsigned CMD_W = ID_W + 2 + LEN_W + ADDR_W;

    logic [CMD_W-1:0]  cmd_in;
    logic [CMD_W-1:0]  head;
    logic              head_valid;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [LEN_W-1:0]  head_len;
    logic [1:0]        head_type;
    logic [ID_W-1:0]   head_id;

    logic              burst_r;
    logic [LEN_W-1:0]  left_r;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        type_r;
    logic [LEN_W-1:0]  len_r;

    logic              start_c;
    logic              beat_c;
    logic              gen_last_c;
    logic              wrap_bad_c;
    logic              id_err_c;
    logic [1:0]        head_eff_c;
    logic [1:0]        cur_type_c;
    logic [LEN_W-1:0]  cur_len_c;
    logic [ADDR_W-1:0] next_addr_c;
    logic [ERR_W-1:0]  cause_c;

    // Next beat address; WRAP relies on len being 2^k-1 so len doubles as the in-block mask
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0]        typ,
                                                    input logic [LEN_W-1:0]  len);
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'(len);
        case (typ)
            BURST_FIXED: next_addr = a;
            BURST_WRAP:  next_addr = (a & ~mask) | ((a + ADDR_W'(1)) & mask);
            default:     next_addr = a + ADDR_W'(1);
        endcase
    endfunction

    assign cmd_in = {arid, rburst, rlen, raddr};
    assign push   = rcmd && !fifo_full;
    assign pop    = start_c;

    simul_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head),
        .valid (head_valid),
        .full  (fifo_full)
    );

    assign head_addr = head[ADDR_W-1:0];
    assign head_len  = head[ADDR_W +: LEN_W];
    assign head_type = head[ADDR_W + LEN_W +: 2];
    assign head_id   = head[ADDR_W + LEN_W + 2 +: ID_W];

    always_comb begin
        start_c     = head_valid && data_stb && !burst_r;
        beat_c      = data_stb && (burst_r || head_valid);
        wrap_bad_c  = (head_type == BURST_WRAP) && !wrap_len_ok(32'(head_len));
        head_eff_c  = (wrap_bad_c || (head_type == BURST_RSVD)) ? BURST_INCR : head_type;
        cur_type_c  = start_c ? head_eff_c : type_r;
        cur_len_c   = start_c ? head_len : len_r;
        gen_last_c  = 1'b0;
        if (burst_r)      gen_last_c = (left_r == LEN_W'(1));
        else if (start_c) gen_last_c = (head_len == '0);
        addr_out    = start_c ? head_addr : addr_r;
        burst       = burst_r || start_c;
        next_addr_c = next_addr(addr_out, cur_type_c, cur_len_c);
    end

    always_comb begin
        cause_c               = '0;
        cause_c[ERR_LAST]     = data_stb && (last != gen_last_c);
        cause_c[ERR_OVERRUN]  = rcmd && fifo_full;
        cause_c[ERR_UNDERRUN] = data_stb && !beat_c;
        cause_c[ERR_WRAP_LEN] = start_c && wrap_bad_c;
        cause_c[ERR_ID]       = id_err_c;
    end

`ifdef SIMUL_AXI_READ_ID_CHECK_EN
    logic [ID_W-1:0] id_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        id_r <= '0;
        else if (start_c) id_r <= head_id;
    end

    assign id_err_c = beat_c && (rid != (start_c ? head_id : id_r));
`else
    logic id_unused;
    assign id_unused = ^{rid, head_id};
    assign id_err_c  = 1'b0;
`endif

    // Burst state: a single-beat burst never sets burst_r
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_r   <= 1'b0;
            left_r    <= '0;
            addr_r    <= '0;
            type_r    <= BURST_FIXED;
            len_r     <= '0;
            err_out   <= 1'b0;
            err_flags <= '0;
        end else begin
            if (start_c) begin
                burst_r <= (head_len != '0);
                left_r  <= head_len;
                type_r  <= head_eff_c;
                len_r   <= head_len;
                addr_r  <= next_addr_c;
            end else if (burst_r && data_stb) begin
                left_r <= left_r - LEN_W'(1);
                addr_r <= next_addr_c;
                if (gen_last_c) burst_r <= 1'b0;
            end
            err_out   <= |cause_c;
            err_flags <= err_flags | cause_c;
        end
    end

endmodule

// File: tb/tb_simul_axi_read_tracker.sv
// Self-checking bench for simul_axi_read_tracker: directed vector table, corner sequences and random traffic vs a queue model.
module tb_simul_axi_read_tracker;
    import simul_axi_pkg::*;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned ID_W   = 6;
    localparam int unsigned DEPTH  = 64;

    typedef struct packed {
        logic [1:0]        typ;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } cmd_t;

    typedef struct packed {
        logic [1:0]             typ;
        logic [ADDR_W-1:0]      addr;
        logic [LEN_W-1:0]       len;
        logic [3:0][ADDR_W-1:0] exp;
        logic                   wrap_err;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rcmd = 1'b0;
    logic [ADDR_W-1:0] raddr = '0;
    logic [LEN_W-1:0]  rlen = '0;
    logic [1:0]        rburst = '0;
    logic [ID_W-1:0]   arid = '0;
    logic              data_stb = 1'b0;
    logic              last = 1'b0;
    logic [ID_W-1:0]   rid = '0;
    logic [ADDR_W-1:0] addr_out;
    logic              burst;
    logic              err_out;
    logic [4:0]        err_flags;

    int errors = 0;
    int checks = 0;

    // Reference model state
    cmd_t            m_q[$];
    int unsigned     m_addrs[$];
    logic [ID_W-1:0] m_id = '0;
    logic [4:0]      m_flags = '0;
    logic            m_err = 1'b0;

    vec_t            vt[7];
    cmd_t            nc = '0;
    logic [ADDR_W-1:0] seen;
    logic            id_exp;

    simul_axi_read_tracker #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .ID_W       (ID_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rcmd      (rcmd),
        .raddr     (raddr),
        .rlen      (rlen),
        .rburst    (rburst),
        .arid      (arid),
        .data_stb  (data_stb),
        .last      (last),
        .rid       (rid),
        .addr_out  (addr_out),
        .burst     (burst),
        .err_out   (err_out),
        .err_flags (err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] typ, input int unsigned addr,
                                input int unsigned len, input int unsigned id);
        cmd_t c;
        c.typ  = typ;
        c.addr = ADDR_W'(addr);
        c.len  = LEN_W'(len);
        c.id   = ID_W'(id);
        return c;
    endfunction

    // Expand a command into its full list of beat addresses; returns 1 for an illegal WRAP length
    function automatic logic build_addrs(input cmd_t c);
        int unsigned n, a, base;
        logic        wrap_ok;
        n       = 32'(c.len) + 1;
        a       = 32'(c.addr);
        wrap_ok = (c.typ == 2'd2) && (n == 2 || n == 4 || n == 8 || n == 16);
        base    = a - (a % n);
        m_addrs.delete();
        for (int unsigned i = 0; i < n; i++) begin
            if (c.typ == 2'd0)  m_addrs.push_back(a);
            else if (wrap_ok)   m_addrs.push_back(base + ((a - base + i) % n));
            else                m_addrs.push_back((a + i) % (1 << ADDR_W));
        end
        return (c.typ == 2'd2) && !wrap_ok;
    endfunction

    function automatic logic exp_gen_last();
        if (m_addrs.size() != 0) return m_addrs.size() == 1;
        if (m_q.size() != 0)     return m_q[0].len == '0;
        return 1'b0;
    endfunction

    function automatic logic [ID_W-1:0] exp_rid();
        if (m_addrs.size() != 0) return m_id;
        if (m_q.size() != 0)     return m_q[0].id;
        return '0;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_addrs.delete();
        m_id    = '0;
        m_flags = '0;
        m_err   = 1'b0;
    endfunction

    // One clock of the model: returns combinational expectations, advances to post-edge state
    function automatic void model_cycle(input logic rc, input cmd_t c, input logic ds, input logic lst,
                                        input logic [ID_W-1:0] id_in, output logic eb,
                                        output logic eav, output logic [ADDR_W-1:0] ea);
        logic [4:0] causes;
        logic       full;
        logic       gl;
        cmd_t       h;
        causes = '0;
        full   = (m_q.size() == DEPTH);
        gl     = exp_gen_last();
        eb     = (m_addrs.size() != 0);
        eav    = eb;
        ea     = eb ? ADDR_W'(m_addrs[0]) : '0;
        if (ds) begin
            if (m_addrs.size() != 0) begin
                causes[4] = (id_in != m_id);
                void'(m_addrs.pop_front());
            end else if (m_q.size() != 0) begin
                h         = m_q.pop_front();
                causes[3] = build_addrs(h);
                m_id      = h.id;
                causes[4] = (id_in != h.id);
                eb        = 1'b1;
                eav       = 1'b1;
                ea        = ADDR_W'(m_addrs[0]);
                void'(m_addrs.pop_front());
            end else begin
                causes[2] = 1'b1;
            end
            causes[0] = (lst != gl);
        end
        if (rc) begin
            if (full) causes[1] = 1'b1;
            else      m_q.push_back(c);
        end
`ifndef SIMUL_AXI_READ_ID_CHECK_EN
        causes[4] = 1'b0;
`endif
        m_err   = |causes;
        m_flags = m_flags | causes;
    endfunction

    // Called at posedge+1; drives inputs, checks near the falling edge, returns at next posedge+1
    task automatic cycle(input logic rc, input cmd_t c, input logic ds, input logic lst,
                         input logic [ID_W-1:0] id_in, output logic [ADDR_W-1:0] obs);
        logic              eb, eav;
        logic [ADDR_W-1:0] ea;
        rcmd = rc; raddr = c.addr; rlen = c.len; rburst = c.typ; arid = c.id;
        data_stb = ds; last = lst; rid = id_in;
        #4;
        chk("err_out", 32'(err_out), 32'(m_err));
        chk("err_flags", 32'(err_flags), 32'(m_flags));
        model_cycle(rc, c, ds, lst, id_in, eb, eav, ea);
        chk("burst", 32'(burst), 32'(eb));
        if (eav) chk("addr_out", 32'(addr_out), 32'(ea));
        obs = addr_out;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rcmd = 1'b0; data_stb = 1'b0; last = 1'b0;
        reset = 1'b1;
        #4;
        chk("rst_addr_out", 32'(addr_out), 32'd0);
        chk("rst_burst", 32'(burst), 32'd0);
        chk("rst_err_out", 32'(err_out), 32'd0);
        chk("rst_err_flags", 32'(err_flags), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vt[0] = '{typ: 2'd1, addr: 10'h3FE, len: 4'd3, exp: {10'h001, 10'h000, 10'h3FF, 10'h3FE}, wrap_err: 1'b0};
        vt[1] = '{typ: 2'd2, addr: 10'h006, len: 4'd3, exp: {10'h005, 10'h004, 10'h007, 10'h006}, wrap_err: 1'b0};
        vt[2] = '{typ: 2'd2, addr: 10'h006, len: 4'd2, exp: {10'h000, 10'h008, 10'h007, 10'h006}, wrap_err: 1'b1};
        vt[3] = '{typ: 2'd0, addr: 10'h010, len: 4'd1, exp: {10'h000, 10'h000, 10'h010, 10'h010}, wrap_err: 1'b0};
        vt[4] = '{typ: 2'd2, addr: 10'h00D, len: 4'd1, exp: {10'h000, 10'h000, 10'h00C, 10'h00D}, wrap_err: 1'b0};
        vt[5] = '{typ: 2'd3, addr: 10'h3FF, len: 4'd1, exp: {10'h000, 10'h000, 10'h000, 10'h3FF}, wrap_err: 1'b0};
        vt[6] = '{typ: 2'd2, addr: 10'h00B, len: 4'd3, exp: {10'h00A, 10'h009, 10'h008, 10'h00B}, wrap_err: 1'b0};

        do_reset();

        // Directed address sequences
        for (int i = 0; i < 7; i++) begin
            do_reset();
            cycle(1'b1, mk(vt[i].typ, 32'(vt[i].addr), 32'(vt[i].len), 32'(i)), 1'b0, 1'b0, '0, seen);
            for (int b = 0; b <= int'(vt[i].len); b++) begin
                cycle(1'b0, nc, 1'b1, (b == int'(vt[i].len)), ID_W'(i), seen);
                chk("tbl_addr", 32'(seen), 32'(vt[i].exp[b]));
            end
            chk("tbl_flags", 32'(err_flags), 32'({1'b0, vt[i].wrap_err, 3'b000}));
        end

        // FIXED burst with a premature last on beat 3
        do_reset();
        cycle(1'b1, mk(2'd0, 32'h010, 7, 1), 1'b0, 1'b0, '0, seen);
        for (int b = 1; b <= 8; b++) begin
            cycle(1'b0, nc, 1'b1, (b == 3) || (b == 8), ID_W'(1), seen);
            chk("fixed_addr", 32'(seen), 32'h010);
            if (b == 3) chk("fixed_err_pulse", 32'(err_out), 32'd1);
            if (b == 4) chk("fixed_err_clear", 32'(err_out), 32'd0);
        end
        chk("fixed_flags", 32'(err_flags), 32'h01);

        // Overrun on the 65th command, then drain and underrun
        do_reset();
        for (int i = 0; i < 65; i++) cycle(1'b1, mk(2'd1, 32'(i), 0, 2), 1'b0, 1'b0, '0, seen);
        chk("ovr_flags", 32'(err_flags), 32'h02);
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, nc, 1'b1, 1'b1, ID_W'(2), seen);
            chk("drain_addr", 32'(seen), 32'(i));
        end
        chk("drain_flags", 32'(err_flags), 32'h02);
        cycle(1'b0, nc, 1'b1, 1'b0, '0, seen);
        chk("udr_flags", 32'(err_flags), 32'h06);

        // ID mismatch
        do_reset();
        cycle(1'b1, mk(2'd1, 32'h020, 0, 5), 1'b0, 1'b0, '0, seen);
        cycle(1'b0, nc, 1'b1, 1'b1, ID_W'(6), seen);
`ifdef SIMUL_AXI_READ_ID_CHECK_EN
        id_exp = 1'b1;
`else
        id_exp = 1'b0;
`endif
        chk("id_flag", 32'(err_flags[4]), 32'(id_exp));

        // Reset asserted during beat 2 of a 4-beat burst
        do_reset();
        cycle(1'b1, mk(2'd1, 32'h100, 3, 3), 1'b0, 1'b0, '0, seen);
        cycle(1'b0, nc, 1'b1, 1'b0, ID_W'(3), seen);
        data_stb = 1'b1; last = 1'b0; rcmd = 1'b0;
        #1;
        chk("mid_burst", 32'(burst), 32'd1);
        chk("mid_addr", 32'(addr_out), 32'h101);
        reset = 1'b1;
        #1;
        chk("async_addr", 32'(addr_out), 32'd0);
        chk("async_burst", 32'(burst), 32'd0);
        chk("async_err_out", 32'(err_out), 32'd0);
        chk("async_flags", 32'(err_flags), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b0, nc, 1'b1, 1'b0, '0, seen);
        chk("post_rst_udr", 32'(err_flags), 32'h04);
        chk("post_rst_pulse", 32'(err_out), 32'd1);

        // Random traffic against the model
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int n = 0; n < 200; n++) begin
                logic              rc, ds, lst;
                logic [ID_W-1:0]   idv;
                int unsigned       len;
                len = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
                rc  = ($urandom_range(0, 2) == 0);
                ds  = ($urandom_range(0, 1) == 0);
                lst = exp_gen_last() ^ ($urandom_range(0, 15) == 0);
                idv = exp_rid() ^ (($urandom_range(0, 19) == 0) ? ID_W'(1) : '0);
                cycle(rc, mk(2'($urandom_range(0, 3)), $urandom_range(0, 1023), len, $urandom_range(0, 63)),
                      ds, lst, idv, seen);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
